vco_drive_filter: RTL and testbench

- First-order IIR low-pass (exponential moving average) filter, unsigned, 32-bit.
- Smooths the NCO frequency control word (FCW) produced by the DPLL phase-error integrator before it reaches the NCO phase accumulator.
- Time constant is 2^pAlpha filter updates. Updates happen only on clock-enable (the NCO rate enable).
- Uses an extended-precision accumulator, so there is no truncation deadband: a constant input is reproduced exactly at the output.

---
 rtl/vco_drive_filter_pkg.sv | 8 +
 rtl/vco_drive_filter.sv | 38 +++
 tb/tb_vco_drive_filter.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/vco_drive_filter_pkg.sv
// Types shared by the DPLL integrator, the FCW smoothing filter and the NCO.
package vco_drive_filter_pkg;

  localparam int FCW_W = 32;

  typedef logic [FCW_W-1:0] fcw_t;

endpackage : vco_drive_filter_pkg

// File: rtl/vco_drive_filter.sv
// Exponential moving average on the NCO frequency control word.
// The accumulator keeps pAlpha fractional bits, so a constant input settles exactly.
module vco_drive_filter
  import vco_drive_filter_pkg::*;
#(
  parameter fcw_t pDefaultValue = 32'h3555_5555,
  parameter int   pAlpha        = 1
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             CE,
  input  logic [FCW_W-1:0] In,
  output logic [FCW_W-1:0] Out
);

  localparam int ACC_W = FCW_W + pAlpha;

  if (pAlpha < 0 || pAlpha > 16) begin : gBadAlpha
    $error("vco_drive_filter: pAlpha must be within 0..16");
  end

  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] nextAcc;

  // acc - (acc >> pAlpha) never exceeds the headroom left for one more sample
  assign nextAcc = acc - (acc >> pAlpha) + ACC_W'(In);

  always_ff @(posedge Clk) begin
    if (Rst) begin
      acc <= ACC_W'(pDefaultValue) << pAlpha;
    end else if (CE) begin
      acc <= nextAcc;
    end
  end

  assign Out = acc[ACC_W-1:pAlpha];

endmodule : vco_drive_filter

// File: tb/tb_vco_drive_filter.sv
// Directed bench for vco_drive_filter: three instances cover pAlpha = 1, 4 and 0.
module tb_vco_drive_filter;
  import vco_drive_filter_pkg::*;

  localparam fcw_t D = 32'h3555_5555;

  logic Clk = 1'b0;
  always #5 Clk = ~Clk;

  logic Rst1 = 1'b1, CE1 = 1'b0;
  logic Rst4 = 1'b1, CE4 = 1'b0;
  logic Rst0 = 1'b1, CE0 = 1'b0;
  fcw_t In1 = '0, In4 = '0, In0 = '0;
  fcw_t Out1, Out4, Out0;

  int total = 0;
  int bad   = 0;

  // Hand-derived Out - D after k updates for a +0x100 step at pAlpha=1
  logic [31:0] stepTbl [12] = '{32'h80, 32'hC0, 32'hE0, 32'hF0, 32'hF8, 32'hFC,
                                32'hFE, 32'hFF, 32'hFF, 32'h100, 32'h100, 32'h100};

  vco_drive_filter #(.pDefaultValue(D), .pAlpha(1)) u1 (
    .Clk(Clk), .Rst(Rst1), .CE(CE1), .In(In1), .Out(Out1));
  vco_drive_filter #(.pDefaultValue(D), .pAlpha(4)) u4 (
    .Clk(Clk), .Rst(Rst4), .CE(CE4), .In(In4), .Out(Out4));
  vco_drive_filter #(.pDefaultValue(D), .pAlpha(0)) u0 (
    .Clk(Clk), .Rst(Rst0), .CE(CE0), .In(In0), .Out(Out0));

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic test_reset();
    Rst1 = 1'b1; Rst4 = 1'b1; Rst0 = 1'b1;
    tick(); tick();
    total++;
    if (Out1 !== D) begin bad++; $display("FAIL reset_a1 got=%h exp=%h", Out1, D); end
    total++;
    if (Out4 !== D) begin bad++; $display("FAIL reset_a4 got=%h exp=%h", Out4, D); end
    total++;
    if (Out0 !== D) begin bad++; $display("FAIL reset_a0 got=%h exp=%h", Out0, D); end
    Rst1 = 1'b0; Rst4 = 1'b0; Rst0 = 1'b0;
    CE1 = 1'b0; In1 = 32'h0;
    for (int i = 0; i < 10; i++) begin
      tick();
      total++;
      if (Out1 !== D) begin bad++; $display("FAIL hold_no_ce cyc=%0d got=%h exp=%h", i, Out1, D); end
    end
  endtask

  task automatic test_step();
    Rst1 = 1'b1; tick(); Rst1 = 1'b0;
    In1 = D + 32'h100; CE1 = 1'b1;
    for (int k = 0; k < 12; k++) begin
      tick();
      total++;
      if (Out1 !== D + stepTbl[k])
        begin bad++; $display("FAIL step k=%0d got=%h exp=%h", k + 1, Out1, D + stepTbl[k]); end
    end
    CE1 = 1'b0;
  endtask

  task automatic test_ce_gating();
    Rst1 = 1'b1; tick(); Rst1 = 1'b0;
    In1 = D + 32'h100;
    for (int p = 0; p < 12; p++) begin
      CE1 = 1'b1;
      tick();
      CE1 = 1'b0;
      total++;
      if (Out1 !== D + stepTbl[p])
        begin bad++; $display("FAIL ce_pulse p=%0d got=%h exp=%h", p, Out1, D + stepTbl[p]); end
      for (int h = 0; h < 3; h++) begin
        tick();
        total++;
        if (Out1 !== D + stepTbl[p])
          begin bad++; $display("FAIL ce_hold p=%0d h=%0d got=%h exp=%h", p, h, Out1, D + stepTbl[p]); end
      end
    end
  endtask

  task automatic test_extremes();
    fcw_t prev;
    bit   reached;
    Rst4 = 1'b1; tick(); Rst4 = 1'b0;
    In4 = 32'hFFFF_FFFF; CE4 = 1'b1;
    prev = D; reached = 1'b0;
    for (int i = 0; i < 1000 && !reached; i++) begin
      tick();
      total++;
      if (Out4 < prev) begin bad++; $display("FAIL rise_mono cyc=%0d got=%h prev=%h", i, Out4, prev); end
      prev = Out4;
      if (Out4 === 32'hFFFF_FFFF) reached = 1'b1;
    end
    total++;
    if (!reached) begin bad++; $display("FAIL rise_reach got=%h exp=ffffffff", Out4); end
    for (int i = 0; i < 20; i++) begin
      tick();
      total++;
      if (Out4 !== 32'hFFFF_FFFF) begin bad++; $display("FAIL rise_stay got=%h exp=ffffffff", Out4); end
    end
    In4 = 32'h0;
    prev = Out4; reached = 1'b0;
    for (int i = 0; i < 1000 && !reached; i++) begin
      tick();
      total++;
      if (Out4 > prev) begin bad++; $display("FAIL decay_mono cyc=%0d got=%h prev=%h", i, Out4, prev); end
      prev = Out4;
      if (Out4 === 32'h0) reached = 1'b1;
    end
    total++;
    if (!reached) begin bad++; $display("FAIL decay_reach got=%h exp=0", Out4); end
    for (int i = 0; i < 20; i++) begin
      tick();
      total++;
      if (Out4 !== 32'h0) begin bad++; $display("FAIL decay_stay got=%h exp=0", Out4); end
    end
    CE4 = 1'b0;
  endtask

  task automatic test_pass_through();
    fcw_t last;
    Rst0 = 1'b1; tick(); Rst0 = 1'b0;
    CE0 = 1'b1;
    for (int i = 0; i < 16; i++) begin
      last = (i == 0) ? 32'hFFFF_FFFF : (i == 1) ? 32'h0 : fcw_t'($urandom);
      In0 = last;
      tick();
      total++;
      if (Out0 !== last) begin bad++; $display("FAIL pass i=%0d got=%h exp=%h", i, Out0, last); end
    end
    CE0 = 1'b0;
    for (int i = 0; i < 5; i++) begin
      In0 = fcw_t'($urandom);
      tick();
      total++;
      if (Out0 !== last) begin bad++; $display("FAIL pass_hold i=%0d got=%h exp=%h", i, Out0, last); end
    end
  endtask

  task automatic test_mid_reset();
    Rst1 = 1'b1; tick(); Rst1 = 1'b0;
    In1 = D + 32'h100; CE1 = 1'b1;
    tick(); tick(); tick();
    total++;
    if (Out1 !== D + 32'hE0) begin bad++; $display("FAIL mid_pre got=%h exp=%h", Out1, D + 32'hE0); end
    Rst1 = 1'b1;
    tick();
    Rst1 = 1'b0;
    total++;
    if (Out1 !== D) begin bad++; $display("FAIL mid_rst got=%h exp=%h", Out1, D); end
    for (int k = 0; k < 3; k++) begin
      tick();
      total++;
      if (Out1 !== D + stepTbl[k])
        begin bad++; $display("FAIL mid_restart k=%0d got=%h exp=%h", k + 1, Out1, D + stepTbl[k]); end
    end
    CE1 = 1'b0;
  endtask

  initial begin
    test_reset();
    test_step();
    test_ce_gating();
    test_extremes();
    test_pass_through();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_vco_drive_filter
